// File: rtl/bus_ram.sv
// bus_ram: windowed single-port data RAM on the processor bus with selectable
// read latency, read-during-write policy and an optional clear-after-reset sweep.
module bus_ram #(
  parameter int                    DATA_W         = 8,
  parameter int                    BUS_ADDR_W     = 8,
  parameter int                    MEM_ADDR_W     = 7,
  parameter logic [BUS_ADDR_W-1:0] BASE_ADDR      = 8'h80,
  parameter int                    READ_LAT       = 1,
  parameter int                    RDW_MODE       = 0,
  parameter int                    CLEAR_ON_RESET = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [BUS_ADDR_W-1:0] BUS_ADDR,
  input  logic [DATA_W-1:0]     BUS_DATA_IN,
  input  logic                  BUS_WE,
  input  logic                  BUS_RE,
  output logic [DATA_W-1:0]     BUS_DATA_OUT,
  output logic                  DATA_VALID,
  output logic                  BUSY
);

  localparam int DEPTH = 2**MEM_ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                             state_reg;
  logic                               busy_reg;
  logic [MEM_ADDR_W-1:0]              clr_ptr_reg;
  logic [DATA_W-1:0]                  mem [DEPTH];
  logic [READ_LAT-1:0][DATA_W-1:0]    data_pipe_reg;
  logic [READ_LAT-1:0]                valid_pipe_reg;

  logic                               hit;
  logic [MEM_ADDR_W-1:0]              local_addr;
  logic                               wr_en;
  logic                               rd_en;
  logic [MEM_ADDR_W-1:0]              wr_addr;
  logic [DATA_W-1:0]                  wr_data;

  generate
    if (MEM_ADDR_W < BUS_ADDR_W) begin : g_decode
      assign hit = (BUS_ADDR[BUS_ADDR_W-1:MEM_ADDR_W] == BASE_ADDR[BUS_ADDR_W-1:MEM_ADDR_W]);
    end else begin : g_full_window
      assign hit = 1'b1;
    end
  endgenerate

  assign local_addr = BUS_ADDR[MEM_ADDR_W-1:0];

  // The clear sweep and bus writes share the single write port; BUSY picks the owner.
  assign wr_en   = ~RESET & (busy_reg | (BUS_WE & hit));
  assign wr_addr = busy_reg ? clr_ptr_reg : local_addr;
  assign wr_data = busy_reg ? '0 : BUS_DATA_IN;
  assign rd_en   = ~RESET & BUS_RE & hit & ~busy_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      clr_ptr_reg <= '0;
      if (CLEAR_ON_RESET != 0) begin
        state_reg <= CLEAR;
        busy_reg  <= 1'b1;
      end else begin
        state_reg <= READY;
        busy_reg  <= 1'b0;
      end
    end else if (state_reg == CLEAR) begin
      clr_ptr_reg <= clr_ptr_reg + MEM_ADDR_W'(1);
      if (clr_ptr_reg == MEM_ADDR_W'(DEPTH - 1)) begin
        state_reg <= READY;
        busy_reg  <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Stage 0 captures the word at the accepting edge; later stages only shift,
  // so a write after capture can never disturb data already in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_pipe_reg  <= '0;
      valid_pipe_reg <= '0;
    end else begin
      valid_pipe_reg[0] <= rd_en;
      if (rd_en) begin
        if ((RDW_MODE != 0) && BUS_WE) begin
          data_pipe_reg[0] <= BUS_DATA_IN;
        end else begin
          data_pipe_reg[0] <= mem[local_addr];
        end
      end
      for (int i = 1; i < READ_LAT; i++) begin
        valid_pipe_reg[i] <= valid_pipe_reg[i-1];
        if (valid_pipe_reg[i-1]) begin
          data_pipe_reg[i] <= data_pipe_reg[i-1];
        end
      end
    end
  end

  assign BUS_DATA_OUT = data_pipe_reg[READ_LAT-1];
  assign DATA_VALID   = valid_pipe_reg[READ_LAT-1];
  assign BUSY         = busy_reg;

endmodule

// File: tb/tb_bus_ram.sv
// Testbench for bus_ram: three instances (1-cycle old-data, 1-cycle new-data,
// 2-cycle old-data) share one bus; read results are scoreboarded per instance.
module tb_bus_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] din;
  logic       we;
  logic       re;

  logic [7:0] out0, out1, out2;
  logic       v0, v1, v2;
  logic       b0, b1, b2;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_ram #(.READ_LAT(1), .RDW_MODE(0)) u0 (
    .CLK(clk), .RESET(rst), .BUS_ADDR(addr), .BUS_DATA_IN(din), .BUS_WE(we),
    .BUS_RE(re), .BUS_DATA_OUT(out0), .DATA_VALID(v0), .BUSY(b0));

  bus_ram #(.READ_LAT(1), .RDW_MODE(1)) u1 (
    .CLK(clk), .RESET(rst), .BUS_ADDR(addr), .BUS_DATA_IN(din), .BUS_WE(we),
    .BUS_RE(re), .BUS_DATA_OUT(out1), .DATA_VALID(v1), .BUSY(b1));

  bus_ram #(.READ_LAT(2), .RDW_MODE(0)) u2 (
    .CLK(clk), .RESET(rst), .BUS_ADDR(addr), .BUS_DATA_IN(din), .BUS_WE(we),
    .BUS_RE(re), .BUS_DATA_OUT(out2), .DATA_VALID(v2), .BUSY(b2));

  // Scoreboard pop side: every valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (v0 === 1'b1) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL u0_unexpected_valid got data=%h want no pulse", out0);
      end else if (out0 !== q0[0]) begin
        n_bad++;
        $display("FAIL u0_read_data got %h want %h", out0, q0[0]);
      end
      if (q0.size() != 0) void'(q0.pop_front());
    end
    if (v1 === 1'b1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL u1_unexpected_valid got data=%h want no pulse", out1);
      end else if (out1 !== q1[0]) begin
        n_bad++;
        $display("FAIL u1_read_data got %h want %h", out1, q1[0]);
      end
      if (q1.size() != 0) void'(q1.pop_front());
    end
    if (v2 === 1'b1) begin
      n_cmp++;
      if (q2.size() == 0) begin
        n_bad++;
        $display("FAIL u2_unexpected_valid got data=%h want no pulse", out2);
      end else if (out2 !== q2[0]) begin
        n_bad++;
        $display("FAIL u2_read_data got %h want %h", out2, q2[0]);
      end
      if (q2.size() != 0) void'(q2.pop_front());
    end
  end

  // Drive one bus cycle from a negedge; returns at the following negedge.
  task automatic drive(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    we = w; re = r; addr = a; din = d;
    $display("bus: we=%b re=%b addr=%h din=%h", w, r, a, d);
    @(negedge clk);
  endtask

  // e_old applies to the old-data instances, e_new to the new-data instance.
  task automatic push_rd(input logic [7:0] e_old, input logic [7:0] e_new);
    q0.push_back(e_old);
    q1.push_back(e_new);
    q2.push_back(e_old);
  endtask

  task automatic test_reset();
    int cnt0, cnt2;
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = 8'h00; din = 8'h00;
    @(negedge clk);
    n_cmp++;
    if (b0 !== 1'b1 || v0 !== 1'b0 || out0 !== 8'h00 || v2 !== 1'b0 || out2 !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_state got busy=%b v0=%b out0=%h v2=%b out2=%h want 1 0 00 0 00",
               b0, v0, out0, v2, out2);
    end
    @(negedge clk);
    rst = 1'b0;
    cnt0 = 0; cnt2 = 0;
    for (int i = 0; i < 300 && (b0 === 1'b1 || b2 === 1'b1); i++) begin
      if (b0 === 1'b1) cnt0++;
      if (b2 === 1'b1) cnt2++;
      @(negedge clk);
    end
    $display("clear: busy cycles u0=%0d u2=%0d", cnt0, cnt2);
    n_cmp++;
    if (cnt0 != 128 || cnt2 != 128) begin
      n_bad++;
      $display("FAIL busy_length got u0=%0d u2=%0d want 128", cnt0, cnt2);
    end
  endtask

  task automatic test_clear_reads();
    push_rd(8'h00, 8'h00); drive(1'b0, 1'b1, 8'h80, 8'h00);
    push_rd(8'h00, 8'h00); drive(1'b0, 1'b1, 8'hBF, 8'h00);
    push_rd(8'h00, 8'h00); drive(1'b0, 1'b1, 8'hFF, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 8'h00);
    n_cmp++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_bad++;
      $display("FAIL clear_reads_pending got %0d want 0", q0.size() + q1.size() + q2.size());
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b0, 8'h85, 8'h5A);
    push_rd(8'h5A, 8'h5A); drive(1'b0, 1'b1, 8'h85, 8'h00);
    n_cmp++;
    if (v0 !== 1'b1 || out0 !== 8'h5A) begin
      n_bad++;
      $display("FAIL write_read_latency got v0=%b out0=%h want 1 5a", v0, out0);
    end
    push_rd(8'h00, 8'h00); drive(1'b0, 1'b1, 8'h86, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 8'h00);
    n_cmp++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_bad++;
      $display("FAIL write_read_pending got %0d want 0", q0.size() + q1.size() + q2.size());
    end
  endtask

  task automatic test_window_miss();
    int pulses;
    push_rd(8'h5A, 8'h5A); drive(1'b0, 1'b1, 8'h85, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h05, 8'hA5);
    pulses = 0;
    we = 1'b0; re = 1'b1; addr = 8'h05;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      re = 1'b0;
      if (v0 === 1'b1 || v1 === 1'b1 || v2 === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL miss_valid got %0d pulses want 0", pulses);
    end
    n_cmp++;
    if (out0 !== 8'h5A || out2 !== 8'h5A) begin
      n_bad++;
      $display("FAIL miss_hold got out0=%h out2=%h want 5a", out0, out2);
    end
    push_rd(8'h5A, 8'h5A); drive(1'b0, 1'b1, 8'h85, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 8'h00);
    n_cmp++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_bad++;
      $display("FAIL miss_pending got %0d want 0", q0.size() + q1.size() + q2.size());
    end
  endtask

  task automatic test_rdw();
    drive(1'b1, 1'b0, 8'h90, 8'h11);
    push_rd(8'h11, 8'h22); drive(1'b1, 1'b1, 8'h90, 8'h22);
    push_rd(8'h22, 8'h22); drive(1'b0, 1'b1, 8'h90, 8'h00);
    drive(1'b1, 1'b0, 8'h90, 8'h33);
    push_rd(8'h33, 8'h33); drive(1'b0, 1'b1, 8'h90, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 8'h00);
    n_cmp++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_bad++;
      $display("FAIL rdw_pending got %0d want 0", q0.size() + q1.size() + q2.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    for (int k = 0; k < 4; k++) begin
      a = 8'h80 + 8'(k);
      drive(1'b1, 1'b0, a, 8'(k + 1));
    end
    for (int k = 0; k < 6; k++) begin
      a = 8'h80 + 8'(k);
      if (k < 4) push_rd(8'(k + 1), 8'(k + 1));
      drive(1'b0, (k < 4), a, 8'h00);
      n_cmp++;
      if (v0 !== (k < 4) || v2 !== (k >= 1 && k <= 4)) begin
        n_bad++;
        $display("FAIL stream_valid cycle %0d got v0=%b v2=%b want %b %b",
                 k, v0, v2, (k < 4), (k >= 1 && k <= 4));
      end
    end
    repeat (2) drive(1'b0, 1'b0, 8'h00, 8'h00);
    n_cmp++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_bad++;
      $display("FAIL stream_pending got %0d want 0", q0.size() + q1.size() + q2.size());
    end
  endtask

  task automatic test_reset_midclear();
    int cnt;
    we = 1'b0; re = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (b0 !== 1'b1 || out0 !== 8'h00 || v0 !== 1'b0) begin
      n_bad++;
      $display("FAIL midclear_reset_state got busy=%b out0=%h v0=%b want 1 00 0", b0, out0, v0);
    end
    cnt = 0;
    for (int i = 0; i < 300 && b0 === 1'b1; i++) begin
      cnt++;
      we = (cnt == 10); re = (cnt == 10); addr = 8'h81; din = 8'h77;
      @(negedge clk);
    end
    we = 1'b0; re = 1'b0;
    $display("midclear: busy cycles u0=%0d", cnt);
    n_cmp++;
    if (cnt != 128) begin
      n_bad++;
      $display("FAIL midclear_busy_length got %0d want 128", cnt);
    end
    push_rd(8'h00, 8'h00); drive(1'b0, 1'b1, 8'h81, 8'h00);
    push_rd(8'h00, 8'h00); drive(1'b0, 1'b1, 8'h85, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 8'h00);
    n_cmp++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_bad++;
      $display("FAIL midclear_pending got %0d want 0", q0.size() + q1.size() + q2.size());
    end
  endtask

  initial begin
    test_reset();
    test_clear_reads();
    test_write_read();
    test_window_miss();
    test_rdw();
    test_back_to_back();
    test_reset_midclear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_ram.md
Name: bus_ram

Overview:
- Parametrised, memory-mapped, single-port read/write data memory on the processor bus.
- Adds the following: write enable, address-window decode, selectable 1- or 2-cycle read latency, read-valid strobe, defined read-during-write behaviour and a hardware clear-on-reset sequencer.
- Sits beside the program ROM on the shared 8-bit bus and serves as the processor's data RAM.

Parameters:
- DATA_W, 8, bus/memory word width in bits.
- BUS_ADDR_W, 8, bus address width.
- MEM_ADDR_W, 7, local address width; DEPTH = 2**MEM_ADDR_W; must be <= BUS_ADDR_W.
- BASE_ADDR, 8'h80, window base address; must be DEPTH-aligned.
- READ_LAT, 1, read latency in clock edges; legal values are 1 or 2.
- RDW_MODE, 0, same-address read-during-write: 0 returns old data, 1 returns new data.
- CLEAR_ON_RESET, 1, 1 zeroes every location after reset.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- BUS_ADDR  input  BUS_ADDR_W  bus address.
- BUS_DATA_IN  input  DATA_W  write data.
- BUS_WE  input  1  write strobe, sampled each edge.
- BUS_RE  input  1  read strobe, sampled each edge.
- BUS_DATA_OUT  output  DATA_W  registered read data.
- DATA_VALID  output  1  one-cycle pulse; BUS_DATA_OUT holds the newly read word.
- BUSY  output  1  high while the clear sequence runs; accesses are ignored.

Behaviour:
- Reset (RESET high at an edge):
  - BUS_DATA_OUT=0, DATA_VALID=0, read pipeline flushed.
  - Clear pointer=0.
  - BUSY=1 if CLEAR_ON_RESET, else 0.
  - Memory contents untouched during reset itself.
- State machine, CLEAR_ON_RESET=1:
  - States are CLEAR then READY.
  - CLEAR: one location zeroed per cycle, pointer 0..DEPTH-1, first write on the first edge with RESET low.
  - After writing DEPTH-1 the machine moves to READY and BUSY falls. BUSY is therefore high for exactly DEPTH cycles after reset release.
  - RESET asserted mid-clear restarts from pointer 0.
  - CLEAR_ON_RESET=0: permanently READY, BUSY=0, contents undefined (X) until written.
- Decode:
  - hit = BUS_ADDR[BUS_ADDR_W-1:MEM_ADDR_W] == BASE_ADDR[BUS_ADDR_W-1:MEM_ADDR_W]; always true when MEM_ADDR_W == BUS_ADDR_W.
  - Local address = BUS_ADDR[MEM_ADDR_W-1:0].
  - Miss: no write, no read, DATA_VALID stays 0, BUS_DATA_OUT holds.
- Write:
  - BUS_WE & hit & !BUSY at edge N updates memory at edge N.
  - Accesses while BUSY are dropped silently and are not queued.
- Read:
  - BUS_RE & hit & !BUSY at edge N gives BUS_DATA_OUT updated and DATA_VALID=1 at edge N+READ_LAT-1.
  - The strobe is visible for one cycle, i.e. data is observable in the cycle after edge N for READ_LAT=1.
  - Fully pipelined: one read accepted per cycle, back-to-back valid pulses.
  - BUS_DATA_OUT holds its last value between reads and is never re-zeroed except by RESET.
- Simultaneous BUS_WE and BUS_RE, same address:
  - The write always happens.
  - Read returns pre-write data (RDW_MODE=0) or BUS_DATA_IN (RDW_MODE=1).
  - A write at edge N+1 does not alter read data already captured at edge N, including for READ_LAT=2.
- Address wrap: none inside the window. Local address DEPTH-1 followed by 0 is simply a new access.
- READ_LAT=2 adds one output register stage. The valid pulse and data shift together and are flushed by RESET.

Test Plan:
- Clear sequence (defaults): pulse RESET 2 cycles, release.
  - BUSY high exactly 128 cycles, then low.
  - Reads of 0x80, 0xBF and 0xFF all return 0x00 with one DATA_VALID pulse each.
- Write/read: write 0x5A to 0x85, then RE at 0x85.
  - BUS_DATA_OUT=0x5A with DATA_VALID on the next cycle.
  - A second read at 0x86 returns 0x00.
- Window miss:
  - WE with 0xA5 at 0x05, then RE at 0x05: no DATA_VALID, BUS_DATA_OUT unchanged.
  - Read at 0x85 still returns its prior value.
- Read-during-write:
  - Preload 0x11 at 0x90, then same-cycle WE 0x22 and RE at 0x90.
  - RDW_MODE=0 returns 0x11, RDW_MODE=1 returns 0x22.
  - A following read returns 0x22 in both modes.
- Reset mid-clear:
  - Assert RESET at clear pointer 40, release.
  - BUSY stays high a full 128 further cycles.
  - A WE to 0x81 during BUSY is dropped (later read returns 0x00).
- READ_LAT=2 streaming: reads issued on 4 consecutive cycles at 0x80..0x83, preloaded 0x01..0x04.
  - 4 consecutive DATA_VALID pulses starting 2 cycles after the first RE, data 0x01..0x04 in order.
